// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and sizing helper for the common FIFO family
package fifo_pkg;
    typedef enum logic {FIFO_OUT_COMB = 1'b0, FIFO_OUT_REG = 1'b1} fifo_out_mode_e;
    localparam int FIFO_DEF_AEMPTY_TH = 1;
    localparam int FIFO_DEF_AFULL_MARGIN = 1;
    function automatic int fifo_cnt_bits(input int cap);
        return $clog2(cap + 1);
    endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: pointer over 0..DEPTH-1 with explicit wrap, enable and synchronous clear
module fifo_wrap_ptr #(
    parameter int DEPTH = 4,
    parameter int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [PW-1:0] o_ptr
);
    logic [PW-1:0] ptr_q, ptr_d;
    // clear wins over advance; the last slot wraps back to 0 for non-power-of-two depths
    always_comb ptr_d = i_clr ? '0 : !i_en ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    // pointer register
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) ptr_q <= '0;
        else ptr_q <= ptr_d;
    assign o_ptr = ptr_q;
endmodule

// File: rtl/fifo_flush_level_data_type.sv
// fifo_flush_level_data_type: typed FIFO with flush, occupancy count, level flags and optional output register
module fifo_flush_level_data_type
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OUT_REG = 0,
    parameter int CAP = DEPTH + OUT_REG,
    parameter int CNT_BIT = fifo_cnt_bits(CAP),
    parameter int AFULL_TH = DEPTH - FIFO_DEF_AFULL_MARGIN,
    parameter int AEMPTY_TH = FIFO_DEF_AEMPTY_TH,
    parameter type DATA_TYPE = logic [WIDTH-1:0]
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    output logic               o_input_ready,
    input  logic               i_input_valid,
    input  DATA_TYPE           i_input_data,
    input  logic               i_output_ready,
    output logic               o_output_valid,
    output DATA_TYPE           o_output_data,
    output logic [CNT_BIT-1:0] o_count,
    output logic               o_almost_full,
    output logic               o_almost_empty
);
    localparam bit USE_REG = (OUT_REG == int'(FIFO_OUT_REG));
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || AFULL_TH < 1 || AFULL_TH > CAP || AEMPTY_TH < 0 || AEMPTY_TH > CAP - 1
        || (OUT_REG != int'(FIFO_OUT_COMB) && OUT_REG != int'(FIFO_OUT_REG))) begin : g_bad_param
        $error("fifo_flush_level_data_type: illegal parameter combination");
    end

    DATA_TYPE           mem_q [DEPTH];
    DATA_TYPE           oreg_data_q, oreg_data_d;
    logic               oreg_valid_q, oreg_valid_d;
    logic [CNT_BIT-1:0] mem_count_q, mem_count_d;
    logic [CNT_BIT-1:0] count_q, count_d;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               mem_empty, full, push, pop, load, from_mem, bypass, wr_en, rd_en;

    // handshakes; with the output register, memory only fills once the head register is occupied
    always_comb begin
        mem_empty = (mem_count_q == '0);
        full = (mem_count_q == CNT_BIT'(DEPTH));
        o_input_ready = !i_reset && !i_flush && !full;
        o_output_valid = !i_flush && (USE_REG ? oreg_valid_q : !mem_empty);
        o_output_data = USE_REG ? oreg_data_q : mem_q[rd_ptr];
        push = o_input_ready && i_input_valid;
        pop = o_output_valid && i_output_ready;
        load = USE_REG && (!oreg_valid_q || pop);
        from_mem = load && !mem_empty;
        bypass = load && mem_empty && push;
        wr_en = push && !bypass;
        rd_en = USE_REG ? from_mem : pop;
    end

    // next occupancy and head register; flush empties everything at once
    always_comb begin
        mem_count_d = i_flush ? '0 : mem_count_q + CNT_BIT'(wr_en) - CNT_BIT'(rd_en);
        count_d = i_flush ? '0 : count_q + CNT_BIT'(push) - CNT_BIT'(pop);
        oreg_valid_d = i_flush ? 1'b0 : load ? (!mem_empty || push) : oreg_valid_q;
        oreg_data_d = from_mem ? mem_q[rd_ptr] : bypass ? i_input_data : oreg_data_q;
    end

    // control state with asynchronous reset
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            mem_count_q <= '0;
            count_q <= '0;
            oreg_valid_q <= 1'b0;
        end else begin
            mem_count_q <= mem_count_d;
            count_q <= count_d;
            oreg_valid_q <= oreg_valid_d;
        end

    // payload storage carries no reset
    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_ptr] <= i_input_data;
        oreg_data_q <= oreg_data_d;
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_flush), .i_en(wr_en), .o_ptr(wr_ptr)
    );
    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_flush), .i_en(rd_en), .o_ptr(rd_ptr)
    );

    assign o_count = count_q;
    assign o_almost_full = (count_q >= CNT_BIT'(AFULL_TH));
    assign o_almost_empty = (count_q <= CNT_BIT'(AEMPTY_TH));

    // occupancy stays in range and matches memory plus head register
    always_ff @(posedge i_clk)
        if (!i_reset) begin
            assert (count_q <= CNT_BIT'(CAP));
            assert (!pop || o_output_valid);
            assert (count_q == mem_count_q + CNT_BIT'(oreg_valid_q));
        end
endmodule

// File: doc/fifo_flush_level_data_type.md
Name: fifo_flush_level_data_type

Overview:
- Parametrised typed FIFO, the next generation of the team's common FIFO.
- Adds synchronous flush, an occupancy count output, and almost-full/almost-empty flags.
- Adds an optional registered output stage (OUT_REG) that removes the memory read path from the consumer timing.
- Sits in npu_v2 common, between streaming producers and consumers: DMA-to-buffer and PE result drain paths.

Parameters:
- WIDTH, 8, payload width used when DATA_TYPE is left at its default.
- DEPTH, 4, memory entries; any value >= 2, power of two not required.
- OUT_REG, 0, 0 = head read combinationally from memory; 1 = head held in an output register.
- CAP, DEPTH+OUT_REG, derived total capacity; do not override.
- CNT_BIT, $clog2(CAP+1), derived occupancy width.
- AFULL_TH, DEPTH-1, almost-full threshold; 1..CAP.
- AEMPTY_TH, 1, almost-empty threshold; 0..CAP-1.
- DATA_TYPE, logic[WIDTH-1:0], payload type.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush request.
- o_input_ready  out  1  FIFO can accept a word.
- i_input_valid  in  1  producer word valid.
- i_input_data  in  DATA_TYPE  producer word.
- i_output_ready  in  1  consumer ready.
- o_output_valid  out  1  head word valid.
- o_output_data  out  DATA_TYPE  head word.
- o_count  out  CNT_BIT  total words held (memory plus output register).
- o_almost_full  out  1  o_count >= AFULL_TH.
- o_almost_empty  out  1  o_count <= AEMPTY_TH.

Behaviour:
- Reset (i_reset=1, asynchronous): pointers, counts and output-register valid go to 0. Outputs during and after reset: o_output_valid=0, o_count=0, o_almost_empty=1, o_almost_full=0. o_input_ready=0 while i_reset is high, 1 on the first cycle after. Memory and data registers are not reset; o_output_data is don't-care while invalid. Reset mid-stream discards all contents.
- Push = o_input_ready & i_input_valid. Pop = o_output_valid & i_output_ready. Both are evaluated at the rising edge.
- OUT_REG=0:
  - o_input_ready = (count != DEPTH).
  - o_output_valid = (count != 0).
  - o_output_data = mem[rd_ptr].
  - A word pushed at edge N is visible immediately after edge N.
- OUT_REG=1:
  - The output register loads when it is empty or is being popped this edge.
  - Source when loading: memory head if memory is non-empty; otherwise the pushed input word (bypass). A bypassed word is not written to memory.
  - o_input_ready = (mem_count != DEPTH).
  - o_output_valid = output-register valid.
  - Write-to-valid latency is 1 edge, same as OUT_REG=0.
  - Ordering must be strict FIFO in every case.
- Pointers wrap from DEPTH-1 to 0 with an explicit compare, not modulo-2^n.
- Simultaneous push and pop: o_count unchanged; data order preserved. When full, push is blocked even if a pop occurs that same cycle; there is no same-cycle pass-through on full.
- o_count: +1 on push only, -1 on pop only, unchanged otherwise. It is never driven outside 0..CAP.
- Flags are combinational from the registered o_count; they have no extra latency.
- Flush: while i_flush=1, o_input_ready=0 and o_output_valid=0, so no handshake can complete. At the edge where i_flush=1, all counts, pointers and output-register valid clear to 0. Flush has priority over push and pop. A flush lasting several cycles holds the FIFO empty.
- Overflow and underflow are structurally impossible. Simulation assertions check o_count <= CAP, and check that a pop only occurs when valid.
- Elaboration checks: DEPTH >= 2, AFULL_TH within 1..CAP, AEMPTY_TH within 0..CAP-1, OUT_REG in {0,1}.

Decomposition:
- fifo_pkg holds:
  - the function fifo_cnt_bits(cap);
  - the enum fifo_out_mode_e {FIFO_OUT_COMB, FIFO_OUT_REG}, used for OUT_REG;
  - the default threshold constants.
- One sub-module, fifo_wrap_ptr. It is a DEPTH-parametrised wrapping pointer with enable and synchronous clear, instantiated twice (write and read). The output register stays inline.

Test Plan:
- DEPTH=3, OUT_REG=0: push 0x11,0x22,0x33 -> o_input_ready=0 and o_count=3. Pop 3 -> data 0x11,0x22,0x33. Repeat 4 rounds -> order correct across non-power-of-two wrap.
- DEPTH=4, OUT_REG=1: push 0xA5 into an empty FIFO -> o_output_valid=1 the next cycle with 0xA5 (bypass). Fill to o_count=5 -> o_input_ready=0.
- Simultaneous push and pop at o_count=2, 20 cycles -> o_count stays 2, output sequence matches input sequence; a pop at full does not admit a same-cycle push.
- AFULL_TH=3, AEMPTY_TH=1, DEPTH=4: o_count 0,1,2,3,4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1.
- o_count=3, i_flush held 2 cycles with i_input_valid=1 and i_output_ready=1 -> no handshakes; afterwards o_count=0, o_output_valid=0, o_input_ready=1.
- Assert i_reset asynchronously mid-cycle at o_count=2 -> o_output_valid and o_count drop to 0 without waiting for a clock edge. After release, push 0x5A -> output 0x5A only.
